// File: rtl/eat_event_generator.sv
// Turns player/object pixel overlaps into per-level "eaten" masks and a spaced
// train of single-cycle score pulses, gold first, issued after each frame commit.
module eat_event_generator #(
  parameter int NUM_GOLD    = 8,
  parameter int NUM_DIAMOND = 16,
  parameter int IDX_W       = 4,
  parameter int CNT_W       = 5
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic                   levelRestart,
  input  logic                   playerDR,
  input  logic                   goldDR,
  input  logic [IDX_W-1:0]       goldIdx,
  input  logic                   diamondDR,
  input  logic [IDX_W-1:0]       diamondIdx,
  output logic                   player_eat_gold,
  output logic                   player_eat_dimond,
  output logic [NUM_GOLD-1:0]    gold_eaten_mask,
  output logic [NUM_DIAMOND-1:0] diamond_eaten_mask,
  output logic                   all_diamonds_eaten
);

  localparam int SUM_W = CNT_W + 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {IDLE, GOLD, GAP_G, DIAM, GAP_D} state_t;

  state_t                 state;
  logic [NUM_GOLD-1:0]    gold_pend;
  logic [NUM_DIAMOND-1:0] diam_pend;
  logic [NUM_GOLD-1:0]    gold_hit;
  logic [NUM_DIAMOND-1:0] diam_hit;
  logic [CNT_W-1:0]       gold_cnt;
  logic [CNT_W-1:0]       diam_cnt;
  logic [CNT_W-1:0]       gold_cnt_next;
  logic [CNT_W-1:0]       diam_cnt_next;
  logic [SUM_W-1:0]       gold_add;
  logic [SUM_W-1:0]       diam_add;

  // Out-of-range indices simply match no decoder bit. An object already pending
  // in the commit cycle is not re-armed, so it cannot be counted twice.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_GOLD; gi++) begin : g_gold_hit
      assign gold_hit[gi] = playerDR && goldDR && (goldIdx == IDX_W'(gi)) &&
                            !gold_eaten_mask[gi] && !(startOfFrame && gold_pend[gi]);
    end
    for (gi = 0; gi < NUM_DIAMOND; gi++) begin : g_diam_hit
      assign diam_hit[gi] = playerDR && diamondDR && (diamondIdx == IDX_W'(gi)) &&
                            !diamond_eaten_mask[gi] && !(startOfFrame && diam_pend[gi]);
    end
  endgenerate

  function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] cnt,
                                                  input logic [SUM_W-1:0] add,
                                                  input logic             dec);
    logic [SUM_W-1:0] sum;
    begin
      sum = SUM_W'(cnt) + add - SUM_W'(dec);
      next_count = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
    end
  endfunction

  assign gold_add      = startOfFrame ? SUM_W'($countones(gold_pend)) : '0;
  assign diam_add      = startOfFrame ? SUM_W'($countones(diam_pend)) : '0;
  assign gold_cnt_next = next_count(gold_cnt, gold_add, state == GOLD);
  assign diam_cnt_next = next_count(diam_cnt, diam_add, state == DIAM);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      gold_pend          <= '0;
      diam_pend          <= '0;
      gold_eaten_mask    <= '0;
      diamond_eaten_mask <= '0;
      all_diamonds_eaten <= 1'b0;
    end else if (levelRestart) begin
      gold_pend          <= '0;
      diam_pend          <= '0;
      gold_eaten_mask    <= '0;
      diamond_eaten_mask <= '0;
      all_diamonds_eaten <= 1'b0;
    end else begin
      if (startOfFrame) begin
        gold_eaten_mask    <= gold_eaten_mask | gold_pend;
        diamond_eaten_mask <= diamond_eaten_mask | diam_pend;
        gold_pend          <= gold_hit;
        diam_pend          <= diam_hit;
      end else begin
        gold_pend <= gold_pend | gold_hit;
        diam_pend <= diam_pend | diam_hit;
      end
      all_diamonds_eaten <= &diamond_eaten_mask;
    end
  end

  // Pulses are registered alongside the state so each lasts exactly one cycle
  // and a gap state always separates two of them.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state             <= IDLE;
      gold_cnt          <= '0;
      diam_cnt          <= '0;
      player_eat_gold   <= 1'b0;
      player_eat_dimond <= 1'b0;
    end else if (levelRestart) begin
      state             <= IDLE;
      gold_cnt          <= '0;
      diam_cnt          <= '0;
      player_eat_gold   <= 1'b0;
      player_eat_dimond <= 1'b0;
    end else begin
      gold_cnt          <= gold_cnt_next;
      diam_cnt          <= diam_cnt_next;
      player_eat_gold   <= 1'b0;
      player_eat_dimond <= 1'b0;
      unique case (state)
        IDLE, GAP_G: begin
          if (gold_cnt != '0) begin
            state           <= GOLD;
            player_eat_gold <= 1'b1;
          end else if (diam_cnt != '0) begin
            state             <= DIAM;
            player_eat_dimond <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        GAP_D: begin
          if (diam_cnt != '0) begin
            state             <= DIAM;
            player_eat_dimond <= 1'b1;
          end else if (gold_cnt != '0) begin
            state           <= GOLD;
            player_eat_gold <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        GOLD:    state <= GAP_G;
        DIAM:    state <= GAP_D;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eat_event_generator.sv
// Randomized bench for eat_event_generator against an object-set level model
// of eaten objects, pending hits and expected pulse timing.
module tb_eat_event_generator;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        startOfFrame = 1'b0;
  logic        levelRestart = 1'b0;
  logic        playerDR = 1'b0;
  logic        goldDR = 1'b0;
  logic [3:0]  goldIdx = '0;
  logic        diamondDR = 1'b0;
  logic [3:0]  diamondIdx = '0;
  logic        player_eat_gold;
  logic        player_eat_dimond;
  logic [7:0]  gold_eaten_mask;
  logic [15:0] diamond_eaten_mask;
  logic        all_diamonds_eaten;

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  int gold_q[$];
  int diam_q[$];
  bit overlap_seen = 0;
  bit adjacent_seen = 0;
  bit prev_pulse = 0;

  bit [7:0]  m_gmask = '0, m_gframe = '0;
  bit [15:0] m_dmask = '0, m_dframe = '0;
  int m_new_g = 0, m_new_d = 0;

  eat_event_generator #(.NUM_GOLD(8), .NUM_DIAMOND(16), .IDX_W(4), .CNT_W(5)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .levelRestart(levelRestart),
    .playerDR(playerDR), .goldDR(goldDR), .goldIdx(goldIdx),
    .diamondDR(diamondDR), .diamondIdx(diamondIdx),
    .player_eat_gold(player_eat_gold), .player_eat_dimond(player_eat_dimond),
    .gold_eaten_mask(gold_eaten_mask), .diamond_eaten_mask(diamond_eaten_mask),
    .all_diamonds_eaten(all_diamonds_eaten)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    if (player_eat_gold && player_eat_dimond) overlap_seen = 1;
    if ((player_eat_gold || player_eat_dimond) && prev_pulse) adjacent_seen = 1;
    if (player_eat_gold) gold_q.push_back(cyc_n);
    if (player_eat_dimond) diam_q.push_back(cyc_n);
    prev_pulse = player_eat_gold || player_eat_dimond;
  end

  task automatic clear_obs();
    gold_q.delete();
    diam_q.delete();
    overlap_seen = 0;
    adjacent_seen = 0;
    m_new_g = 0;
    m_new_d = 0;
  endtask

  // One clock of stimulus; the model applies the eating rules to the same inputs.
  task automatic step(input bit p, input bit g, input int gi, input bit d, input int di,
                      input bit sof, input bit lr);
    bit hg, hd;
    playerDR = p; goldDR = g; goldIdx = gi[3:0];
    diamondDR = d; diamondIdx = di[3:0];
    startOfFrame = sof; levelRestart = lr;
    if (lr) begin
      m_gmask = '0; m_gframe = '0; m_dmask = '0; m_dframe = '0;
    end else begin
      hg = p && g && gi < 8 && !m_gmask[gi] && !(sof && m_gframe[gi]);
      hd = p && d && di < 16 && !m_dmask[di] && !(sof && m_dframe[di]);
      if (sof) begin
        m_new_g += $countones(m_gframe);
        m_new_d += $countones(m_dframe);
        m_gmask |= m_gframe;
        m_dmask |= m_dframe;
        m_gframe = '0;
        m_dframe = '0;
      end
      if (hg) m_gframe[gi] = 1'b1;
      if (hd) m_dframe[di] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Activity that never produces a valid overlap.
  task automatic noise();
    case ($urandom_range(0, 3))
      0: step(1, 0, $urandom_range(0, 15), 0, $urandom_range(0, 15), 0, 0);
      1: step(0, 1, $urandom_range(0, 15), 1, $urandom_range(0, 15), 0, 0);
      2: step(1, 1, $urandom_range(8, 15), 0, $urandom_range(0, 15), 0, 0);
      default: step(0, 0, 0, 0, 0, 0, 0);
    endcase
  endtask

  task automatic overlap(input bit is_gold, input int idx, input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 2) == 0) noise();
      if (is_gold) step(1, 1, idx, 0, $urandom_range(0, 15), 0, 0);
      else step(1, 0, $urandom_range(0, 15), 1, idx, 0, 0);
    end
  endtask

  task automatic commit(output int s);
    s = cyc_n;
    step(0, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_reset();
    int s;
    resetN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      playerDR = 1'($urandom); goldDR = 1'($urandom); goldIdx = 4'($urandom);
      diamondDR = 1'($urandom); diamondIdx = 4'($urandom);
      startOfFrame = 1'($urandom); levelRestart = 1'($urandom);
      @(posedge clk); #1;
      checks++;
      if ({player_eat_gold, player_eat_dimond, gold_eaten_mask, diamond_eaten_mask,
           all_diamonds_eaten} !== 27'd0) begin
        failures++;
        $display("FAIL reset_outputs: got g=%b d=%b gm=%h dm=%h all=%b required all zero",
                 player_eat_gold, player_eat_dimond, gold_eaten_mask, diamond_eaten_mask,
                 all_diamonds_eaten);
      end
    end
    step(0, 0, 0, 0, 0, 0, 0);
    resetN = 1'b1;
    clear_obs();
    repeat (3) begin
      repeat (20) noise();
      commit(s);
    end
    idle(10);
    checks++;
    if (gold_q.size() + diam_q.size() != m_new_g + m_new_d || m_new_g + m_new_d != 0) begin
      failures++;
      $display("FAIL reset_idle_frames: got %0d pulses required 0", gold_q.size() + diam_q.size());
    end
  endtask

  task automatic test_single_gold();
    int s;
    clear_obs();
    overlap(1, 3, 50);
    checks++;
    if (gold_eaten_mask !== 8'h00) begin
      failures++;
      $display("FAIL single_mask_before_commit: got %h required 00", gold_eaten_mask);
    end
    commit(s);
    checks++;
    if (gold_eaten_mask !== 8'h08 || gold_eaten_mask !== m_gmask) begin
      failures++;
      $display("FAIL single_mask: got %h required 08", gold_eaten_mask);
    end
    idle(10);
    checks++;
    if (gold_q.size() != 1 || m_new_g != 1 || diam_q.size() != 0) begin
      failures++;
      $display("FAIL single_count: got gold=%0d diam=%0d required gold=1 diam=0",
               gold_q.size(), diam_q.size());
    end else begin
      checks++;
      if (gold_q[0] != s + 2) begin
        failures++;
        $display("FAIL single_latency: got cycle %0d required %0d", gold_q[0], s + 2);
      end
    end
    clear_obs();
    overlap(1, 3, 20);
    commit(s);
    idle(10);
    checks++;
    if (gold_q.size() != m_new_g || gold_q.size() != 0) begin
      failures++;
      $display("FAIL single_reeat: got %0d pulses required 0", gold_q.size());
    end
  endtask

  task automatic test_mixed();
    int s;
    int order[4] = '{0, 1, 2, 3};
    step(0, 0, 0, 0, 0, 0, 1);
    clear_obs();
    for (int i = 3; i > 0; i--) begin
      int j, t;
      j = $urandom_range(0, i);
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int i = 0; i < 4; i++) begin
      case (order[i])
        0: overlap(1, 0, $urandom_range(3, 12));
        1: overlap(0, 1, $urandom_range(3, 12));
        2: overlap(0, 2, $urandom_range(3, 12));
        default: begin
          noise();
          step(1, 1, 5, 1, 15, 0, 0);
          noise();
        end
      endcase
    end
    commit(s);
    idle(16);
    checks++;
    if (gold_q.size() != 2 || diam_q.size() != 3 || m_new_g != 2 || m_new_d != 3) begin
      failures++;
      $display("FAIL mixed_counts: got gold=%0d diam=%0d required gold=2 diam=3",
               gold_q.size(), diam_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (gold_q[i] != s + 2 + 2 * i) begin
          failures++;
          $display("FAIL mixed_gold_time%0d: got %0d required %0d", i, gold_q[i], s + 2 + 2 * i);
        end
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (diam_q[i] != s + 6 + 2 * i) begin
          failures++;
          $display("FAIL mixed_diam_time%0d: got %0d required %0d", i, diam_q[i], s + 6 + 2 * i);
        end
      end
    end
    checks++;
    if (gold_eaten_mask !== 8'h21 || diamond_eaten_mask !== 16'h8006 ||
        gold_eaten_mask !== m_gmask || diamond_eaten_mask !== m_dmask) begin
      failures++;
      $display("FAIL mixed_masks: got %h/%h required 21/8006", gold_eaten_mask, diamond_eaten_mask);
    end
    checks++;
    if (overlap_seen || adjacent_seen) begin
      failures++;
      $display("FAIL mixed_spacing: got overlap=%0d adjacent=%0d required 0/0",
               overlap_seen, adjacent_seen);
    end
  endtask

  task automatic test_boundary();
    int s;
    clear_obs();
    for (int i = 0; i < 30; i++) begin
      noise();
      step(1, 1, 9, 0, 0, 0, 0);
    end
    commit(s);
    idle(8);
    checks++;
    if (gold_q.size() != 0 || gold_eaten_mask !== m_gmask) begin
      failures++;
      $display("FAIL invalid_index: got pulses=%0d mask=%h required 0 and %h",
               gold_q.size(), gold_eaten_mask, m_gmask);
    end
    repeat (10) noise();
    s = cyc_n;
    step(1, 1, 6, 0, 0, 1, 0);
    checks++;
    if (gold_eaten_mask !== 8'h21) begin
      failures++;
      $display("FAIL sof_hit_deferred_mask: got %h required 21", gold_eaten_mask);
    end
    idle(8);
    checks++;
    if (gold_q.size() != 0) begin
      failures++;
      $display("FAIL sof_hit_deferred_pulse: got %0d pulses required 0", gold_q.size());
    end
    repeat (10) noise();
    commit(s);
    checks++;
    if (gold_eaten_mask !== 8'h61 || gold_eaten_mask !== m_gmask) begin
      failures++;
      $display("FAIL sof_hit_next_mask: got %h required 61", gold_eaten_mask);
    end
    idle(8);
    checks++;
    if (gold_q.size() != 1 || m_new_g != 1) begin
      failures++;
      $display("FAIL sof_hit_next_pulse: got %0d pulses required 1", gold_q.size());
    end
  endtask

  task automatic test_all_diamonds();
    int s;
    int perm[16];
    step(0, 0, 0, 0, 0, 0, 1);
    clear_obs();
    for (int i = 0; i < 16; i++) perm[i] = i;
    for (int i = 15; i > 0; i--) begin
      int j, t;
      j = $urandom_range(0, i);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int f = 0; f < 4; f++) begin
      for (int j = 0; j < 4; j++) overlap(0, perm[f * 4 + j], $urandom_range(2, 8));
      commit(s);
      if (f < 3) begin
        idle(12);
        checks++;
        if (all_diamonds_eaten !== 1'b0) begin
          failures++;
          $display("FAIL all_diam_early: frame %0d got 1 required 0", f);
        end
      end
    end
    checks++;
    if (diamond_eaten_mask !== 16'hffff || all_diamonds_eaten !== 1'b0) begin
      failures++;
      $display("FAIL all_diam_commit: got mask=%h all=%b required ffff/0",
               diamond_eaten_mask, all_diamonds_eaten);
    end
    idle(1);
    checks++;
    if (all_diamonds_eaten !== 1'b1) begin
      failures++;
      $display("FAIL all_diam_flag: got %b required 1", all_diamonds_eaten);
    end
    idle(12);
    checks++;
    if (diam_q.size() != 16 || m_new_d != 16 || overlap_seen || adjacent_seen) begin
      failures++;
      $display("FAIL all_diam_pulses: got %0d (ovl=%0d adj=%0d) required 16",
               diam_q.size(), overlap_seen, adjacent_seen);
    end
  endtask

  task automatic test_level_restart();
    int s, n, total;
    step(0, 0, 0, 0, 0, 0, 1);
    clear_obs();
    overlap(1, 3, 5);
    overlap(1, 1, 5);
    overlap(0, 4, 5);
    overlap(0, 7, 5);
    overlap(0, 9, 5);
    commit(s);
    n = 0;
    for (int i = 0; i < 30 && n < 2; i++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      if (player_eat_gold || player_eat_dimond) n++;
    end
    checks++;
    if (n != 2) begin
      failures++;
      $display("FAIL restart_wait: got %0d pulses before timeout required 2", n);
    end
    step(0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (player_eat_gold !== 1'b0 || player_eat_dimond !== 1'b0) begin
      failures++;
      $display("FAIL restart_drop: got g=%b d=%b required 0/0", player_eat_gold, player_eat_dimond);
    end
    idle(20);
    total = gold_q.size() + diam_q.size();
    checks++;
    if (total != 2) begin
      failures++;
      $display("FAIL restart_no_more_pulses: got %0d total required 2", total);
    end
    checks++;
    if (gold_eaten_mask !== 8'h00 || diamond_eaten_mask !== 16'h0000 ||
        all_diamonds_eaten !== 1'b0) begin
      failures++;
      $display("FAIL restart_state: got %h/%h/%b required 00/0000/0",
               gold_eaten_mask, diamond_eaten_mask, all_diamonds_eaten);
    end
    clear_obs();
    overlap(1, 3, 10);
    commit(s);
    idle(10);
    checks++;
    if (gold_q.size() != 1 || m_new_g != 1 || gold_eaten_mask !== 8'h08) begin
      failures++;
      $display("FAIL restart_reeat: got pulses=%0d mask=%h required 1/08",
               gold_q.size(), gold_eaten_mask);
    end
  endtask

  initial begin
    test_reset();
    test_single_gold();
    test_mixed();
    test_boundary();
    test_all_diamonds();
    test_level_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
